// File: rtl/fwd_ctrl_unit_pkg.sv
// Shared select encoding for the EX-stage operand forwarding muxes.
package fwd_ctrl_unit_pkg;

   // 2'b10 is deliberately unused.
   typedef enum logic [1:0] {
      SelBuf2    = 2'b00,
      SelAluBuf3 = 2'b01,
      SelMux5    = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/fwd_ctrl_unit_match.sv
// Forwarding select for one ID-stage operand, youngest in-flight producer first.
module fwd_ctrl_unit_match
   import fwd_ctrl_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                  id_valid,
   input  logic                  use_src,
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  ex_valid,
   input  logic                  ex_wr_en,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_dest,
   input  logic                  mem_valid,
   input  logic                  mem_wr_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   output fwd_sel_e              sel
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ex_valid & ex_wr_en & (ex_dest == src);
   assign mem_hit = mem_valid & mem_wr_en & (mem_dest == src);

   // A load in EX cannot forward from the ALU; the stall path handles it.
   always_comb begin
      sel = SelBuf2;
      if (id_valid && use_src) begin
         if (ex_hit && !ex_is_load) begin
            sel = SelAluBuf3;
         end else if (mem_hit) begin
            sel = SelMux5;
         end
      end
   end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Operand-forwarding and load-use stall control for the EX-stage operand muxes.
// Optional stall statistics counter enabled by defining FWD_STATS_EN.
module fwd_ctrl_unit
   import fwd_ctrl_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 4
`ifdef FWD_STATS_EN
   ,
   parameter int unsigned CNT_W      = 16
`endif
) (
   input  logic                  in_clk,
   input  logic                  in_reset,
   input  logic                  in_id_valid,
   input  logic [REG_ADDR_W-1:0] in_id_src1,
   input  logic [REG_ADDR_W-1:0] in_id_src2,
   input  logic                  in_id_use_src1,
   input  logic                  in_id_use_src2,
   input  logic [REG_ADDR_W-1:0] in_id_dest,
   input  logic                  in_id_wr_en,
   input  logic                  in_id_is_load,
   input  logic                  in_flush,
   output logic                  out_stall,
   output logic [1:0]            out_cntrl_m2,
   output logic [1:0]            out_cntrl_m3,
   output logic                  out_ex_valid
`ifdef FWD_STATS_EN
   ,
   output logic [CNT_W-1:0]      out_stall_count
`endif
);

   // EX entry (ID->EX buffer) and MEM entry (EX->MEM buffer). The WB entry is
   // never a forwarding source, so it needs no storage here.
   logic                  ex_valid_q;
   logic                  ex_wr_en_q;
   logic                  ex_is_load_q;
   logic [REG_ADDR_W-1:0] ex_dest_q;
   logic                  mem_valid_q;
   logic                  mem_wr_en_q;
   logic [REG_ADDR_W-1:0] mem_dest_q;
   fwd_sel_e              sel_m2_d;
   fwd_sel_e              sel_m3_d;
   fwd_sel_e              sel_m2_q;
   fwd_sel_e              sel_m3_q;
   logic                  load_use;

   fwd_ctrl_unit_match #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_match_op1 (
      .id_valid  (in_id_valid),
      .use_src   (in_id_use_src1),
      .src       (in_id_src1),
      .ex_valid  (ex_valid_q),
      .ex_wr_en  (ex_wr_en_q),
      .ex_is_load(ex_is_load_q),
      .ex_dest   (ex_dest_q),
      .mem_valid (mem_valid_q),
      .mem_wr_en (mem_wr_en_q),
      .mem_dest  (mem_dest_q),
      .sel       (sel_m2_d)
   );

   fwd_ctrl_unit_match #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_match_op2 (
      .id_valid  (in_id_valid),
      .use_src   (in_id_use_src2),
      .src       (in_id_src2),
      .ex_valid  (ex_valid_q),
      .ex_wr_en  (ex_wr_en_q),
      .ex_is_load(ex_is_load_q),
      .ex_dest   (ex_dest_q),
      .mem_valid (mem_valid_q),
      .mem_wr_en (mem_wr_en_q),
      .mem_dest  (mem_dest_q),
      .sel       (sel_m3_d)
   );

   assign load_use = in_id_valid & ex_valid_q & ex_wr_en_q & ex_is_load_q &
                     ((in_id_use_src1 & (in_id_src1 == ex_dest_q)) |
                      (in_id_use_src2 & (in_id_src2 == ex_dest_q)));

   assign out_stall    = load_use;
   assign out_cntrl_m2 = sel_m2_q;
   assign out_cntrl_m3 = sel_m3_q;
   assign out_ex_valid = ex_valid_q;

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         ex_valid_q   <= 1'b0;
         ex_wr_en_q   <= 1'b0;
         ex_is_load_q <= 1'b0;
         ex_dest_q    <= '0;
         mem_valid_q  <= 1'b0;
         mem_wr_en_q  <= 1'b0;
         mem_dest_q   <= '0;
         sel_m2_q     <= SelBuf2;
         sel_m3_q     <= SelBuf2;
      end else begin
         mem_valid_q <= ex_valid_q;
         mem_wr_en_q <= ex_wr_en_q;
         mem_dest_q  <= ex_dest_q;
         // Flush and stall both insert a bubble; the held ID instruction is
         // re-evaluated next cycle against the advanced pipeline.
         if (in_flush || load_use) begin
            ex_valid_q   <= 1'b0;
            ex_wr_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_dest_q    <= '0;
            sel_m2_q     <= SelBuf2;
            sel_m3_q     <= SelBuf2;
         end else begin
            ex_valid_q   <= in_id_valid;
            ex_wr_en_q   <= in_id_valid & in_id_wr_en;
            ex_is_load_q <= in_id_valid & in_id_is_load;
            ex_dest_q    <= in_id_dest;
            sel_m2_q     <= sel_m2_d;
            sel_m3_q     <= sel_m3_d;
         end
      end
   end

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         stall_cnt_q <= '0;
      end else if (load_use && !in_flush && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign out_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Self-checking bench for fwd_ctrl_unit: directed table, corner sequences and
// randomized traffic against an instruction-history reference model.
module tb_fwd_ctrl_unit;

   localparam int unsigned AW = 4;
`ifdef FWD_STATS_EN
   localparam int unsigned CW = 8;
`endif

   typedef struct {
      logic          valid;
      logic [AW-1:0] src1;
      logic          use1;
      logic [AW-1:0] src2;
      logic          use2;
      logic [AW-1:0] dest;
      logic          wr;
      logic          ld;
      logic          flush;
   } id_t;

   typedef struct {
      id_t        v;
      logic       stall;
      logic [1:0] m2;
      logic [1:0] m3;
      logic       exv;
   } row_t;

   // One issued instruction as seen by later consumers; bubble has wr=0.
   typedef struct {
      logic          wr;
      logic          ld;
      logic [AW-1:0] dest;
   } hist_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, use1, use2, wr_en, is_load, flush;
   logic [AW-1:0] src1, src2, dest;
   logic          stall;
   logic [1:0]    m2, m3;
   logic          exv;
`ifdef FWD_STATS_EN
   logic [CW-1:0] stall_count;
`endif

   always #5 clk = ~clk;

   fwd_ctrl_unit #(
      .REG_ADDR_W(AW)
`ifdef FWD_STATS_EN
      ,
      .CNT_W     (CW)
`endif
   ) dut (
      .in_clk         (clk),
      .in_reset       (rst),
      .in_id_valid    (id_valid),
      .in_id_src1     (src1),
      .in_id_src2     (src2),
      .in_id_use_src1 (use1),
      .in_id_use_src2 (use2),
      .in_id_dest     (dest),
      .in_id_wr_en    (wr_en),
      .in_id_is_load  (is_load),
      .in_flush       (flush),
      .out_stall      (stall),
      .out_cntrl_m2   (m2),
      .out_cntrl_m3   (m3),
      .out_ex_valid   (exv)
`ifdef FWD_STATS_EN
      ,
      .out_stall_count(stall_count)
`endif
   );

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   // Reference model state.
   hist_t       hist[$];
   logic        m_stall;
   logic [1:0]  e_m2, e_m3;
   logic        e_exv;
   int unsigned m_cnt;
   int unsigned cnt_max;

   // Sampled DUT outputs.
   logic        a_stall;
   logic [1:0]  a_m2, a_m3;
   logic        a_exv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic id_t mk_id(logic v, logic [AW-1:0] s1, logic u1, logic [AW-1:0] s2,
                                 logic u2, logic [AW-1:0] d, logic w, logic l, logic f);
      id_t r;
      r.valid = v; r.src1 = s1; r.use1 = u1; r.src2 = s2; r.use2 = u2;
      r.dest = d; r.wr = w; r.ld = l; r.flush = f;
      return r;
   endfunction

   function automatic row_t mk_row(id_t v, logic s, logic [1:0] a, logic [1:0] b, logic e);
      row_t r;
      r.v = v; r.stall = s; r.m2 = a; r.m3 = b; r.exv = e;
      return r;
   endfunction

   // Select from the two most recent issued instructions, youngest first.
   function automatic logic [1:0] ref_sel(logic valid, logic use_s, logic [AW-1:0] s);
      if (!valid || !use_s) return 2'b00;
      if (hist[0].wr && hist[0].dest == s && !hist[0].ld) return 2'b01;
      if (hist[1].wr && hist[1].dest == s) return 2'b11;
      return 2'b00;
   endfunction

   task automatic model_step(input id_t v, input logic r);
      hist_t n;
      m_stall = v.valid && hist[0].wr && hist[0].ld &&
                ((v.use1 && v.src1 == hist[0].dest) || (v.use2 && v.src2 == hist[0].dest));
      if (r) begin
         hist.delete();
         n = '{wr: 1'b0, ld: 1'b0, dest: '0};
         hist.push_back(n);
         hist.push_back(n);
         e_m2 = 2'b00; e_m3 = 2'b00; e_exv = 1'b0; m_cnt = 0;
      end else begin
         if (m_stall && !v.flush && m_cnt < cnt_max) m_cnt++;
         if (v.flush || m_stall) begin
            n = '{wr: 1'b0, ld: 1'b0, dest: '0};
            e_m2 = 2'b00; e_m3 = 2'b00; e_exv = 1'b0;
         end else begin
            n.wr = v.valid & v.wr; n.ld = v.valid & v.ld; n.dest = v.dest;
            e_m2 = ref_sel(v.valid, v.use1, v.src1);
            e_m3 = ref_sel(v.valid, v.use2, v.src2);
            e_exv = v.valid;
         end
         hist.push_front(n);
         void'(hist.pop_back());
      end
   endtask

   // Present one ID cycle, sample the combinational stall, then the registered outputs.
   task automatic step(input id_t v, input logic r);
      rst = r; id_valid = v.valid; src1 = v.src1; use1 = v.use1; src2 = v.src2;
      use2 = v.use2; dest = v.dest; wr_en = v.wr; is_load = v.ld; flush = v.flush;
      model_step(v, r);
      #1;
      a_stall = stall;
      @(posedge clk);
      #1;
      a_m2 = m2; a_m3 = m3; a_exv = exv;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " stall"}, {31'd0, a_stall}, {31'd0, m_stall});
      chk({tag, " m2"}, {30'd0, a_m2}, {30'd0, e_m2});
      chk({tag, " m3"}, {30'd0, a_m3}, {30'd0, e_m3});
      chk({tag, " ex_valid"}, {31'd0, a_exv}, {31'd0, e_exv});
`ifdef FWD_STATS_EN
      chk({tag, " stall_count"}, 32'(stall_count), m_cnt);
`endif
   endtask

   row_t tbl[17];
   id_t  nop;

   initial begin
`ifdef FWD_STATS_EN
      cnt_max = (1 << CW) - 1;
`else
      cnt_max = 32'hFFFF;
`endif
      m_cnt = 0;
      nop = mk_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

      //                 v  s1 u1 s2 u2 d  wr ld fl      stall m2     m3     exv
      tbl[0]  = mk_row(mk_id(1, 0, 0, 0, 0, 3, 1, 0, 0),  0, 2'b00, 2'b00, 1);
      tbl[1]  = mk_row(mk_id(1, 1, 1, 3, 1, 9, 1, 0, 0),  0, 2'b00, 2'b01, 1);
      tbl[2]  = mk_row(mk_id(1, 0, 0, 0, 0, 5, 1, 0, 0),  0, 2'b00, 2'b00, 1);
      tbl[3]  = mk_row(mk_id(1, 0, 0, 0, 0, 6, 1, 0, 0),  0, 2'b00, 2'b00, 1);
      tbl[4]  = mk_row(mk_id(1, 5, 1, 2, 0, 10, 1, 0, 0), 0, 2'b11, 2'b00, 1);
      tbl[5]  = mk_row(mk_id(1, 0, 0, 0, 0, 7, 1, 0, 0),  0, 2'b00, 2'b00, 1);
      tbl[6]  = mk_row(mk_id(1, 0, 0, 0, 0, 7, 1, 0, 0),  0, 2'b00, 2'b00, 1);
      tbl[7]  = mk_row(mk_id(1, 7, 1, 7, 1, 11, 1, 0, 0), 0, 2'b01, 2'b01, 1);
      tbl[8]  = mk_row(mk_id(1, 0, 0, 0, 0, 4, 1, 1, 0),  0, 2'b00, 2'b00, 1);
      tbl[9]  = mk_row(mk_id(1, 1, 0, 4, 1, 12, 1, 0, 0), 1, 2'b00, 2'b00, 0);
      tbl[10] = mk_row(mk_id(1, 1, 0, 4, 1, 12, 1, 0, 0), 0, 2'b00, 2'b11, 1);
      tbl[11] = mk_row(mk_id(1, 0, 0, 0, 0, 8, 1, 1, 0),  0, 2'b00, 2'b00, 1);
      tbl[12] = mk_row(mk_id(1, 8, 1, 0, 0, 13, 1, 0, 1), 1, 2'b00, 2'b00, 0);
      tbl[13] = mk_row(mk_id(1, 8, 1, 0, 0, 13, 1, 0, 0), 0, 2'b11, 2'b00, 1);
      tbl[14] = mk_row(mk_id(0, 13, 1, 13, 1, 1, 1, 0, 0), 0, 2'b00, 2'b00, 0);
      tbl[15] = mk_row(mk_id(1, 0, 0, 0, 0, 0, 1, 0, 0),  0, 2'b00, 2'b00, 1);
      tbl[16] = mk_row(mk_id(1, 0, 1, 0, 1, 2, 1, 0, 0),  0, 2'b01, 2'b01, 1);

      // Reset state.
      step(nop, 1'b1);
      step(nop, 1'b1);
      chk("reset m2", {30'd0, a_m2}, 32'd0);
      chk("reset m3", {30'd0, a_m3}, 32'd0);
      chk("reset ex_valid", {31'd0, a_exv}, 32'd0);
`ifdef FWD_STATS_EN
      chk("reset stall_count", 32'(stall_count), 32'd0);
`endif

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, 1'b0);
         chk($sformatf("row%0d stall", i), {31'd0, a_stall}, {31'd0, tbl[i].stall});
         chk($sformatf("row%0d m2", i), {30'd0, a_m2}, {30'd0, tbl[i].m2});
         chk($sformatf("row%0d m3", i), {30'd0, a_m3}, {30'd0, tbl[i].m3});
         chk($sformatf("row%0d ex_valid", i), {31'd0, a_exv}, {31'd0, tbl[i].exv});
      end
`ifdef FWD_STATS_EN
      // One stall (row 9) counted; the flushed load-use (row 12) is not.
      chk("table stall_count", 32'(stall_count), 32'd1);
`endif

      // Reset with valid writers in EX and MEM: nothing may forward afterwards.
      step(mk_id(1, 0, 0, 0, 0, 7, 1, 0, 0), 1'b0);
      step(mk_id(1, 0, 0, 0, 0, 7, 1, 0, 0), 1'b0);
      step(mk_id(1, 7, 1, 7, 1, 9, 1, 0, 0), 1'b1);
      chk("midreset m2", {30'd0, a_m2}, 32'd0);
      chk("midreset m3", {30'd0, a_m3}, 32'd0);
      chk("midreset ex_valid", {31'd0, a_exv}, 32'd0);
      step(mk_id(1, 7, 1, 7, 1, 9, 1, 0, 0), 1'b0);
      chk("postreset m2", {30'd0, a_m2}, 32'd0);
      chk("postreset m3", {30'd0, a_m3}, 32'd0);
      chk("postreset ex_valid", {31'd0, a_exv}, 32'd1);

`ifdef FWD_STATS_EN
      // Repeated load-use pairs drive the counter into saturation.
      for (int i = 0; i < 300; i++) begin
         step(mk_id(1, 0, 0, 0, 0, 4, 1, 1, 0), 1'b0);
         step(mk_id(1, 4, 1, 0, 0, 5, 1, 0, 0), 1'b0);
      end
      chk("saturated stall_count", 32'(stall_count), (1 << CW) - 1);
      chk("saturated model", m_cnt, (1 << CW) - 1);
`endif

      // Randomized traffic on a small register window to provoke frequent hits.
      for (int i = 0; i < 600; i++) begin
         id_t v;
         v.valid = ($urandom_range(0, 99) < 85);
         v.src1  = AW'($urandom_range(0, 3));
         v.src2  = AW'($urandom_range(0, 3));
         v.use1  = 1'($urandom_range(0, 1));
         v.use2  = 1'($urandom_range(0, 1));
         v.dest  = AW'($urandom_range(0, 3));
         v.wr    = ($urandom_range(0, 99) < 80);
         v.ld    = ($urandom_range(0, 99) < 30);
         v.flush = ($urandom_range(0, 99) < 8);
         step(v, ($urandom_range(0, 99) < 2));
         chk_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
